mixsx32_idx_recover: RTL and testbench
======================================

Name: mixsx32_idx_recover

Overview:
Recovers the per-word index vector that a mixsx32 pass used on a 64-bit-word block.
- Inputs: the original block c, the mixed block m, and the candidate word pool x.
- For each 64-bit word i, it finds which 32-bit x word was XORed into the low half: x[j] == c_lo[i] ^ m_lo[i].
- It reports the index vector plus per-word integrity errors.
- It sits on the receive/verify side of the mixing datapath.
- Scanning is constant-time, so latency does not depend on the secret data.

Parameters:
CWORDS64, 2, number of 64-bit words in c and m (>=1)
XWORDS32, 2, number of 32-bit candidate words in x (>=2; IDX_WIDTH = $clog2(XWORDS32))

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
en  input  1  start request, sampled in IDLE
c  input  CWORDS64*64  original (pre-mix) block; word i at [64i +: 64]
m  input  CWORDS64*64  mixed block; word i at [64i +: 64]
x  input  XWORDS32*32  candidate pool; word j at [32j +: 32]
d_out  output  CWORDS64*IDX_WIDTH  recovered index for word i at [i*IDX_WIDTH +: IDX_WIDTH]
word_err  output  CWORDS64  bit i set = word i failed recovery
busy  output  1  high in LOAD and SCAN
done  output  1  high in DONE

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high. Reset forces:
  - state to IDLE;
  - i, j, and all capture/result registers to 0;
  - outputs d_out, word_err, busy, done to 0.
- Reset asserted mid-operation aborts immediately. No partial results are ever presented.
- States are IDLE, LOAD, SCAN, DONE.
- IDLE:
  - en=1 at a clock edge -> LOAD; otherwise stay.
- LOAD (1 cycle):
  - register c, m, x into internal regs;
  - clear i, j, idx_reg, found, err_reg;
  - -> SCAN.
  - Inputs may change freely after LOAD.
- SCAN (exactly CWORDS64*XWORDS32 cycles), one comparison per cycle for word i, candidate j:
  - diff = c_reg[64i +: 32] ^ m_reg[64i +: 32];
  - hit = (diff == x_reg[32j +: 32]);
  - if hit and found[i]==0: idx_reg[i] <= j, found[i] <= 1. First (lowest j) match wins; later duplicates are ignored.
  - when j == 0: err_reg[i] <= (c_reg[64i+32 +: 32] != m_reg[64i+32 +: 32]). The upper half must pass through unmixed.
  - j increments each cycle. At j==XWORDS32-1, j wraps to 0 and i increments.
  - At i==CWORDS64-1 and j==XWORDS32-1 -> DONE. No early exit on match.
- DONE:
  - done=1;
  - d_out = idx_reg;
  - word_err[i] = err_reg[i] | ~found[i]; an unmatched word reports index 0 with its error bit set.
  - Stays in DONE while en=1; en=0 -> IDLE.
- Output gating: d_out and word_err are 0 in every state except DONE, so no secret-derived value leaks early.
- Latency: en sampled at edge E -> done first high after edge E+2+CWORDS64*XWORDS32. With defaults that is E+6.
- en is ignored outside IDLE and DONE. No restart without passing through IDLE.
- Counters: i is $clog2(CWORDS64)+1 bits wide and j is IDX_WIDTH bits wide; neither ever exceeds its terminal value.

Test Plan:
1. Nominal recovery (defaults).
   - Stimulus: x = {32'hDEADBEEF, 32'h12345678}; c = {64'hAAAAAAAA_55555555, 64'h00000001_00000002}; m = {64'hAAAAAAAA_4761032D, 64'h00000001_DEADBEED}; pulse en.
   - Required: done after 6 edges; d_out = 2'b01; word_err = 2'b00; busy high for exactly 5 cycles.
2. No match.
   - Stimulus: as case 1, but m word0 low = 32'h00000000.
   - Required: d_out = 2'b00; word_err = 2'b01.
3. Upper-half tamper.
   - Stimulus: as case 1, but m word1 high = 32'hAAAAAAAB.
   - Required: d_out = 2'b01; word_err = 2'b10.
4. Duplicate candidates.
   - Stimulus: x = {32'h12345678, 32'h12345678}; both words mixed with that value.
   - Required: d_out = 2'b00 (lowest j wins); word_err = 0.
   - Also required: cycle count identical to case 1 (constant time).
5. Reset mid-SCAN.
   - Stimulus: assert reset 3 cycles after en.
   - Required: next cycle state IDLE; done=0, busy=0, d_out=0, word_err=0.
   - Then: a fresh run reproduces case 1 results.
6. Hold/restart.
   - Stimulus: keep en=1 after done.
   - Required: DONE persists with stable outputs.
   - Then: drop en for 1 cycle -> IDLE with outputs 0; re-raise en -> a new run completes with a new result.

Source files
------------

// File: rtl/mixsx32_idx_recover.sv
// Recovers the per-word x-pool index used by a mixsx32 pass, plus per-word integrity errors.
// The scan always visits every (word, candidate) pair, so latency is data-independent.
module mixsx32_idx_recover #(
    parameter  int CWORDS64  = 2,
    parameter  int XWORDS32  = 2,
    localparam int IDX_WIDTH = $clog2(XWORDS32)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            en,
    input  logic [CWORDS64*64-1:0]          c,
    input  logic [CWORDS64*64-1:0]          m,
    input  logic [XWORDS32*32-1:0]          x,
    output logic [CWORDS64*IDX_WIDTH-1:0]   d_out,
    output logic [CWORDS64-1:0]             word_err,
    output logic                            busy,
    output logic                            done
);

    localparam int IW = $clog2(CWORDS64) + 1;
    localparam logic [IW-1:0]        I_LAST = IW'(CWORDS64 - 1);
    localparam logic [IDX_WIDTH-1:0] J_LAST = IDX_WIDTH'(XWORDS32 - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SCAN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                          r_state;
    logic [IW-1:0]                   r_i;
    logic [IDX_WIDTH-1:0]            r_j;
    logic [CWORDS64*64-1:0]          r_c;
    logic [CWORDS64*64-1:0]          r_m;
    logic [XWORDS32*32-1:0]          r_x;
    logic [CWORDS64*IDX_WIDTH-1:0]   r_idx;
    logic [CWORDS64-1:0]             r_found;
    logic [CWORDS64-1:0]             r_err;
    logic [CWORDS64*IDX_WIDTH-1:0]   r_d_out;
    logic [CWORDS64-1:0]             r_word_err;
    logic                            r_busy;
    logic                            r_done;

    logic [31:0]                     w_diff;
    logic [31:0]                     w_xsel;
    logic                            w_hi_err;
    logic                            w_hit;

    // Select the current word's halves and the current candidate.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_diff   = '0;
        w_hi_err = 1'b0;
        w_xsel   = '0;
        for (int k = 0; k < CWORDS64; k++) begin
            if (r_i == IW'(k)) begin
                w_diff   = r_c[64*k +: 32] ^ r_m[64*k +: 32];
                w_hi_err = (r_c[64*k+32 +: 32] != r_m[64*k+32 +: 32]);
            end
        end
        for (int k = 0; k < XWORDS32; k++) begin
            if (r_j == IDX_WIDTH'(k)) begin
                w_xsel = r_x[32*k +: 32];
            end
        end
    end

    assign w_hit = (w_diff == w_xsel);

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            r_state    <= S_IDLE;
            r_i        <= '0;
            r_j        <= '0;
            r_c        <= '0;
            r_m        <= '0;
            r_x        <= '0;
            r_idx      <= '0;
            r_found    <= '0;
            r_err      <= '0;
            r_d_out    <= '0;
            r_word_err <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // Outputs are registered from the current state; results are exposed only from DONE.
            r_busy     <= (r_state == S_LOAD) || (r_state == S_SCAN);
            r_done     <= (r_state == S_DONE);
            r_d_out    <= (r_state == S_DONE) ? r_idx : '0;
            r_word_err <= (r_state == S_DONE) ? (r_err | ~r_found) : '0;

            case (r_state)
                S_IDLE: begin
                    if (en) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_c     <= c;
                    r_m     <= m;
                    r_x     <= x;
                    r_i     <= '0;
                    r_j     <= '0;
                    r_idx   <= '0;
                    r_found <= '0;
                    r_err   <= '0;
                    r_state <= S_SCAN;
                end
                S_SCAN: begin
                    for (int k = 0; k < CWORDS64; k++) begin
                        if (r_i == IW'(k)) begin
                            if (w_hit && !r_found[k]) begin
                                r_found[k]                      <= 1'b1;
                                r_idx[k*IDX_WIDTH +: IDX_WIDTH] <= r_j;
                            end
                            if (r_j == '0) r_err[k] <= w_hi_err;
                        end
                    end
                    if (r_j == J_LAST) begin
                        r_j <= '0;
                        if (r_i == I_LAST) r_state <= S_DONE;
                        else               r_i     <= r_i + 1'b1;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!en) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign d_out    = r_d_out;
    assign word_err = r_word_err;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_mixsx32_idx_recover.sv
// Self-checking bench for mixsx32_idx_recover: directed cases plus randomized runs
// compared against a word-by-word reference model of the recovery rules.
module tb_mixsx32_idx_recover;

    localparam int CW = 2;
    localparam int XW = 2;
    localparam int IW = $clog2(XW);
    localparam int CB = CW*64;
    localparam int XB = XW*32;
    localparam int DB = CW*IW;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [CB-1:0] c;
    logic [CB-1:0] m;
    logic [XB-1:0] x;
    logic [DB-1:0] d_out;
    logic [CW-1:0] word_err;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    mixsx32_idx_recover #(.CWORDS64(CW), .XWORDS32(XW)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .c        (c),
        .m        (m),
        .x        (x),
        .d_out    (d_out),
        .word_err (word_err),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: for each word, the first candidate equal to the low-half XOR; error if none or upper half differs.
    function automatic void model(input logic [CB-1:0] cc, input logic [CB-1:0] mm,
                                  input logic [XB-1:0] xx,
                                  output logic [DB-1:0] d, output logic [CW-1:0] e);
        d = '0;
        e = '0;
        for (int w = 0; w < CW; w++) begin
            logic [31:0] diff;
            bit          found;
            diff  = cc[64*w +: 32] ^ mm[64*w +: 32];
            found = 0;
            for (int j = 0; j < XW; j++) begin
                if (!found && xx[32*j +: 32] == diff) begin
                    d[w*IW +: IW] = IW'(j);
                    found = 1;
                end
            end
            e[w] = !found || (cc[64*w+32 +: 32] != mm[64*w+32 +: 32]);
        end
    endfunction

    task automatic run(input logic [CB-1:0] cc, input logic [CB-1:0] mm, input logic [XB-1:0] xx,
                       input bit hold, output logic [DB-1:0] got_d, output logic [CW-1:0] got_e,
                       output int lat);
        logic [DB-1:0] exp_d;
        logic [CW-1:0] exp_e;
        int            busy_cnt;
        model(cc, mm, xx, exp_d, exp_e);
        @(negedge clk);
        c  = cc;
        m  = mm;
        x  = xx;
        en = 1'b1;
        @(posedge clk);
        #1;
        check("pre_done", done, 0);
        check("pre_dout", d_out, 0);
        if (!hold) en = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (lat < 50) begin
            @(posedge clk);
            lat++;
            #1;
            if (busy) busy_cnt++;
            if (done) break;
            if (lat == 1) begin
                c = {$urandom, $urandom, $urandom, $urandom};
                m = {$urandom, $urandom, $urandom, $urandom};
                x = {$urandom, $urandom};
            end
            check("scan_dout_gated", d_out, 0);
        end
        check("latency", lat, 2 + CW*XW);
        check("busy_cycles", busy_cnt, 1 + CW*XW);
        check("d_out", d_out, exp_d);
        check("word_err", word_err, exp_e);
        got_d = d_out;
        got_e = word_err;
        if (!hold) begin
            @(posedge clk);
            #1;
            check("idle_done", done, 0);
            check("idle_busy", busy, 0);
            check("idle_dout", d_out, 0);
            check("idle_err", word_err, 0);
        end
    endtask

    logic [XB-1:0] x1;
    logic [CB-1:0] c1;
    logic [CB-1:0] m1;
    logic [DB-1:0] rd;
    logic [CW-1:0] re;
    int            lat1;
    int            lat;

    initial begin
        x1 = {32'hDEADBEEF, 32'h12345678};
        c1 = {64'hAAAAAAAA_55555555, 64'h00000001_00000002};
        m1 = {64'hAAAAAAAA_4761032D, 64'h00000001_DEADBEED};
        reset = 1'b1;
        en    = 1'b0;
        c     = '0;
        m     = '0;
        x     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_dout", d_out, 0);
        check("rst_err", word_err, 0);
        @(negedge clk);
        reset = 1'b0;

        // 1. nominal
        run(c1, m1, x1, 0, rd, re, lat1);
        check("c1_dout", rd, 2'b01);
        check("c1_err", re, 2'b00);

        // 2. no match in word 0
        run(c1, {m1[127:32], 32'h00000000}, x1, 0, rd, re, lat);
        check("c2_dout", rd, 2'b00);
        check("c2_err", re, 2'b01);

        // 3. upper-half tamper in word 1
        run(c1, {32'hAAAAAAAB, m1[95:0]}, x1, 0, rd, re, lat);
        check("c3_dout", rd, 2'b01);
        check("c3_err", re, 2'b10);

        // 4. duplicate candidates
        run(c1, {64'hAAAAAAAA_4761032D, 64'h00000001_1234567A},
            {32'h12345678, 32'h12345678}, 0, rd, re, lat);
        check("c4_dout", rd, 2'b00);
        check("c4_err", re, 2'b00);
        check("c4_const_time", lat, lat1);

        // 5. reset during SCAN
        @(negedge clk);
        c  = c1;
        m  = m1;
        x  = x1;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("c5_done", done, 0);
        check("c5_busy", busy, 0);
        check("c5_dout", d_out, 0);
        check("c5_err", word_err, 0);
        @(negedge clk);
        reset = 1'b0;
        begin
            bit saw_done = 0;
            repeat (8) begin
                @(posedge clk);
                #1;
                if (done || busy) saw_done = 1;
            end
            check("c5_stays_idle", saw_done, 0);
        end
        run(c1, m1, x1, 0, rd, re, lat);
        check("c5_rerun_dout", rd, 2'b01);
        check("c5_rerun_err", re, 2'b00);

        // 6. hold en in DONE, then drop for one cycle and restart with new data
        run(c1, m1, x1, 1, rd, re, lat);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("c6_hold_done", done, 1);
            check("c6_hold_dout", d_out, 2'b01);
            check("c6_hold_err", word_err, 2'b00);
        end
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        run(c1, {m1[127:32], 32'h00000001 ^ 32'h12345678 ^ 32'h00000003}, x1, 0, rd, re, lat);
        check("c6_new_dout", rd, 2'b00);
        check("c6_new_err", re, 2'b00);

        // randomized runs: mix of matches, misses, duplicates and tampering
        for (int t = 0; t < 24; t++) begin
            logic [CB-1:0] rc;
            logic [CB-1:0] rm;
            logic [XB-1:0] rx;
            for (int j = 0; j < XW; j++) rx[32*j +: 32] = $urandom;
            if ($urandom_range(3) == 0) rx[32 +: 32] = rx[31:0];
            for (int w = 0; w < CW; w++) begin
                rc[64*w +: 64] = {$urandom, $urandom};
                if ($urandom_range(3) != 0)
                    rm[64*w +: 32] = rc[64*w +: 32] ^ rx[32*$urandom_range(XW-1) +: 32];
                else
                    rm[64*w +: 32] = $urandom;
                rm[64*w+32 +: 32] = rc[64*w+32 +: 32];
                if ($urandom_range(4) == 0) rm[64*w+32 +: 32] ^= 32'h1 << $urandom_range(31);
            end
            run(rc, rm, rx, 0, rd, re, lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
